mod_reduce: RTL and testbench
=============================

MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 SHALL have parameter PW, default 12, product width (matches the 12-bit multiplier product).
REQ-002 SHALL have parameter NW, default 6, modulus and remainder width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to reduce the current prod/modulus.
REQ-006 SHALL have port prod  input  PW  unsigned operand (multiplier product).
REQ-007 SHALL have port modulus  input  NW  unsigned modulus n.
REQ-008 SHALL have port busy  output  1  high while a reduction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port rem_out  output  NW  prod mod n.
REQ-011 SHALL have port err  output  1  modulus was zero for the completed request.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIN.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture prod and modulus into internal registers, clear the partial remainder and the bit counter, and enter CALC (if modulus!=0) or FIN (if modulus==0).
REQ-014 SHALL ignore start in CALC and FIN; captured operands are unaffected by later input changes.
REQ-015 SHALL perform restoring shift-subtract in CALC, one product bit per cycle, MSB first: r' = {r, prod[i]}; if r' >= n then r' = r' - n.
REQ-016 SHALL hold the partial remainder in NW+1 bits; r < n before each shift, so r' < 2n with no overflow.
REQ-017 SHALL spend exactly PW cycles in CALC, then enter FIN.
REQ-018 SHALL, on entry to FIN, drive done=1 for exactly one cycle and load rem_out; FIN returns to IDLE on the next edge.
REQ-019 SHALL give a latency of PW+1 edges from the start-accept edge to the edge that asserts done (13 with defaults). A modulus-zero request asserts done 1 edge after accept.
REQ-020 SHALL hold busy=1 from the start-accept edge until the edge that asserts done; busy=0 while done=1.
REQ-021 SHALL, for a modulus-zero request, set err=1 and rem_out=0. Otherwise err=0.
REQ-022 SHALL hold rem_out and err stable after done until the next completion; they do not change at start accept.
REQ-023 SHALL accept a new start in the cycle after done (back-to-back throughput PW+2 cycles).
REQ-024 SHALL return rem_out=0 for modulus=1, and rem_out=prod for prod<modulus.

Reset
REQ-025 SHALL, while rst_n=0, immediately force FSM=IDLE, busy=0, done=0, err=0, rem_out=0, and clear counter and internal registers.
REQ-026 SHALL abandon any in-progress reduction on reset with no done pulse; the first start after rst_n rises is handled normally.

Verification
REQ-027 SHALL be verified by: prod=1645 (35*47), modulus=59, start pulse -> done exactly 13 edges later, rem_out=52, err=0, busy high for 13 cycles.
REQ-028 SHALL be verified by: prod=4095, modulus=63 -> rem_out=0; then prod=4095, modulus=2 -> rem_out=1.
REQ-029 SHALL be verified by: prod=12, modulus=13 -> rem_out=12; prod=100, modulus=1 -> rem_out=0.
REQ-030 SHALL be verified by: modulus=0, prod=77 -> done 1 edge after accept, err=1, rem_out=0; the next valid request clears err.
REQ-031 SHALL be verified by: start re-asserted with different prod at cycle 5 of CALC -> ignored, result matches the first operands; start the cycle after done -> accepted.
REQ-032 SHALL be verified by: rst_n pulsed low at cycle 7 of CALC -> outputs 0 asynchronously, no done; a subsequent prod=1000, modulus=37 -> rem_out=1.

Source files
------------

// File: rtl/mod_reduce.sv
// Sequential modular reducer: computes prod mod modulus by restoring
// shift-subtract, one product bit per cycle, MSB first.
module mod_reduce #(
  parameter int PW = 12,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] prod,
  input  logic [NW-1:0] modulus,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] rem_out,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  state_t        state, next;
  logic [PW-1:0] prod_q;
  logic [NW-1:0] mod_q;
  logic [NW:0]   r, r_sh, r_next;
  logic [CW-1:0] cnt;
  logic          mod_zero;

  assign mod_zero = (mod_q == '0);
  assign busy     = (state != IDLE);

  // r < n before the shift, so the shifted value fits in NW+1 bits
  always_comb begin
    r_sh   = (r << 1) | {{NW{1'b0}}, prod_q[PW-1]};
    r_next = r_sh;
    if (r_sh >= {1'b0, mod_q}) r_next = r_sh - {1'b0, mod_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = (modulus == '0) ? FIN : CALC;
      CALC:    if (cnt == LAST) next = FIN;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mod_q   <= '0;
      r       <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      rem_out <= '0;
      err     <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            prod_q <= prod;
            mod_q  <= modulus;
            r      <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          r      <= r_next;
          prod_q <= prod_q << 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          rem_out <= mod_zero ? '0 : r[NW-1:0];
          err     <= mod_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: vector table plus scoreboard of
// expected results popped whenever done pulses.
module tb_mod_reduce;

  localparam int PW = 12;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] prod = '0;
  logic [NW-1:0] modulus = '0;
  logic          busy, done, err;
  logic [NW-1:0] rem_out;

  mod_reduce #(.PW(PW), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prod(prod), .modulus(modulus),
    .busy(busy), .done(done), .rem_out(rem_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    logic [NW-1:0] modulus;
    logic [NW-1:0] rem;
    logic          err;
  } vec_t;

  typedef struct {
    logic [NW-1:0] rem;
    logic          err;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [NW-1:0] last_rem = '0;
  logic          last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rem_out", 32'(rem_out), 32'(e.rem));
        check("err", 32'(err), 32'(e.err));
        last_rem = e.rem;
        last_err = e.err;
      end
    end
  end

  // Called just after an active edge with the DUT idle or pulsing done.
  task automatic run_req(input logic [PW-1:0] p, input logic [NW-1:0] m,
                         input logic [NW-1:0] er, input logic ee, input int glitch_at);
    int   edges, busy_cnt, exp_lat;
    exp_t e;
    exp_lat = (m == '0) ? 1 : PW + 1;
    e.rem = er;
    e.err = ee;
    start = 1'b1; prod = p; modulus = m;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_rem_at_accept", 32'(rem_out), 32'(last_rem));
    check("hold_err_at_accept", 32'(err), 32'(last_err));
    edges = 0; busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      if (glitch_at != 0 && edges == glitch_at) begin
        start = 1'b1; prod = ~p; modulus = m + 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{prod: 12'd1645, modulus: 6'd59, rem: 6'd52, err: 1'b0};
    vecs[1] = '{prod: 12'd4095, modulus: 6'd63, rem: 6'd0,  err: 1'b0};
    vecs[2] = '{prod: 12'd4095, modulus: 6'd2,  rem: 6'd1,  err: 1'b0};
    vecs[3] = '{prod: 12'd12,   modulus: 6'd13, rem: 6'd12, err: 1'b0};
    vecs[4] = '{prod: 12'd100,  modulus: 6'd1,  rem: 6'd0,  err: 1'b0};
    vecs[5] = '{prod: 12'd2047, modulus: 6'd60, rem: 6'd7,  err: 1'b0};
    vecs[6] = '{prod: 12'd77,   modulus: 6'd0,  rem: 6'd0,  err: 1'b1};
    vecs[7] = '{prod: 12'd4095, modulus: 6'd33, rem: 6'd3,  err: 1'b0};
    vecs[8] = '{prod: 12'd0,    modulus: 6'd5,  rem: 6'd0,  err: 1'b0};

    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rem", 32'(rem_out), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].prod, vecs[i].modulus, vecs[i].rem, vecs[i].err, 0);
      repeat (2) @(posedge clk);
      #1;
    end

    // start re-asserted mid-CALC is ignored; next start lands in the done cycle
    run_req(12'd1645, 6'd59, 6'd52, 1'b0, 5);
    run_req(12'd4095, 6'd2, 6'd1, 1'b0, 0);
    run_req(12'd12, 6'd13, 6'd12, 1'b0, 0);
    @(posedge clk); #1;

    // reset mid-CALC abandons the request without a done pulse
    start = 1'b1; prod = 12'd1645; modulus = 6'd59;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rem", 32'(rem_out), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    last_rem = '0;
    last_err = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (PW + 4) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_req(12'd1000, 6'd37, 6'd1, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
